// File: rtl/echo_pkg.sv
// Shared constants, sample type, state encoding and saturation helper for the
// echo restore path.
package echo_pkg;

  localparam int DATA_W = 10;
  localparam logic [DATA_W-1:0] ADC_OFFSET = 10'h181;
  localparam logic [DATA_W-1:0] DAC_OFFSET = 10'h200;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Clamp a one-bit-wider signed sum into the signed sample range.
  function automatic sample_t sat_narrow(input logic signed [DATA_W:0] v);
    sample_t r;
    if (v[DATA_W] != v[DATA_W-1]) begin
      r = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      r = v[DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port delay RAM: one write port, one registered read port.
// Callers guarantee read and write never hit the same address in one cycle.
module echo_delay_ram #(
  parameter int DEPTH = 2000,
  parameter int WIDTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents are
  // masked by the fill tracking in the parent rather than cleared here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/echo_fir_restore.sv
// Feed-forward echo restore: data_out = x[n] + (x[n-DELAY] >>> GAIN_SHIFT).
// Define ECHO_SAT_EN to saturate the sum instead of wrapping it.
module echo_fir_restore
  import echo_pkg::*;
#(
  parameter int DELAY      = 2000,
  parameter int GAIN_SHIFT = 1
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pulse,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              primed,
  output logic              overrun
);

  localparam int AW = $clog2(DELAY);
  localparam int CW = $clog2(DELAY + 1);

  state_t                 state;
  logic [AW-1:0]          wr_ptr;
  logic [CW-1:0]          fill_cnt;
  sample_t                x_q;
  logic                   s1;
  logic [DATA_W-1:0]      rd_data;
  logic                   busy;
  logic                   accept;
  sample_t                d;
  sample_t                y_n;
  logic signed [DATA_W:0] y_wide;

  // A sample occupies the pipeline until its valid_out strobe has been issued.
  assign busy   = s1 | valid_out;
  assign accept = pulse & ~busy;

  echo_delay_ram #(
    .DEPTH (DELAY),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_ram (
    .clk     (sysclk),
    .wr_en   (s1),
    .wr_addr (wr_ptr),
    .wr_data (x_q),
    .rd_en   (accept),
    .rd_addr (wr_ptr),
    .rd_data (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    d = '0;
    if (state == RUN) begin
      d = sample_t'(rd_data) >>> GAIN_SHIFT;
    end
    y_wide = {x_q[DATA_W-1], x_q} + {d[DATA_W-1], d};
`ifdef ECHO_SAT_EN
    y_n = sat_narrow(y_wide);
`else
    y_n = y_wide[DATA_W-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      x_q       <= '0;
      s1        <= 1'b0;
      data_out  <= DAC_OFFSET;
      valid_out <= 1'b0;
      primed    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      s1        <= accept;
      valid_out <= s1;
      if (accept) begin
        x_q <= data_in - ADC_OFFSET;
      end
      if (pulse && busy) begin
        overrun <= 1'b1;
      end
      if (s1) begin
        data_out <= y_n + DAC_OFFSET;
        wr_ptr   <= (wr_ptr == AW'(DELAY - 1)) ? '0 : wr_ptr + AW'(1);
        if (state == FILL) begin
          fill_cnt <= fill_cnt + CW'(1);
          if (fill_cnt == CW'(DELAY - 1)) begin
            state  <= RUN;
            primed <= 1'b1;
          end
        end
      end
    end
  end

endmodule
